mc14500b_loader: RTL

Program loader and run sequencer for the MC14500B core. It accepts a program as a byte stream over a valid/ready handshake and buffers the complete program internally. It then replays the program into the core's write port as one word per clock, bracketed by core resets, and releases the core to run. It sits between the host byte source (UART or test harness) and the core's `rst` / `program_write` / `program_cmd` inputs.

---
 rtl/mc14500b_loader_pkg.sv | 27 ++
 rtl/mc14500b_prog_buf.sv | 36 +++
 rtl/mc14500b_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mc14500b_loader_pkg.sv
// Shared types and constants for the MC14500B program loader.
package mc14500b_loader_pkg;

  localparam int unsigned PROG_WORD_W = 12;
  localparam int unsigned OPCODE_W    = 4;

  // MC14500B instruction set, used for the held opcode nibble.
  typedef enum logic [OPCODE_W-1:0] {
    OpNopo = 4'h0, OpLd   = 4'h1, OpLdc  = 4'h2, OpAnd  = 4'h3,
    OpAndc = 4'h4, OpOr   = 4'h5, OpOrc  = 4'h6, OpXnor = 4'h7,
    OpSto  = 4'h8, OpStoc = 4'h9, OpIen  = 4'hA, OpOen  = 4'hB,
    OpJmp  = 4'hC, OpRtn  = 4'hD, OpSkz  = 4'hE, OpNopf = 4'hF
  } instruction_t;

  typedef enum logic [3:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StClr,
    StStream,
    StBoot,
    StRun,
    StErr
  } loader_state_t;

endpackage

// File: rtl/mc14500b_prog_buf.sv
// Program buffer: simple dual-port RAM, synchronous write, 1-cycle read latency.
module mc14500b_prog_buf
  import mc14500b_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [PROG_WORD_W-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [PROG_WORD_W-1:0] rdata_o
);

  logic [PROG_WORD_W-1:0] mem [DEPTH];
  logic [PROG_WORD_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc14500b_loader.sv
// Program loader and run sequencer: buffers a byte-stream program, then
// replays it into the MC14500B write port between core resets and releases it.
module mc14500b_loader
  import mc14500b_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   s_valid,
  input  logic [7:0]             s_data,
  output logic                   s_ready,
  output logic                   core_rst,
  output logic                   core_program_write,
  output logic [PROG_WORD_W-1:0] core_program_cmd,
  output logic                   busy,
  output logic                   running,
  output logic                   err
);

  loader_state_t state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;   // program length, 1..256
  logic [8:0]    idx_q, idx_d;   // words written / streamed so far
  instruction_t  op_q, op_d;

  logic s_ready_q, s_ready_d;
  logic core_rst_q, core_rst_d;
  logic pwrite_q, pwrite_d;
  logic busy_q, busy_d;
  logic running_q, running_d;
  logic err_q, err_d;

  logic                   accept;
  logic [8:0]             idx_inc;
  logic                   buf_we;
  logic                   buf_re;
  logic [AW-1:0]          buf_raddr;
  logic [PROG_WORD_W-1:0] buf_rdata;

  assign accept  = s_valid && s_ready_q;
  assign idx_inc = idx_q + 9'd1;

  // Next-state, counter and buffer-port control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    op_d      = op_q;
    buf_we    = 1'b0;
    buf_re    = 1'b0;
    buf_raddr = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StLen;
      StLen: begin
        if (start) begin
          state_d = StLen;
        end else if (accept) begin
          cnt_d   = {(s_data == 8'h00), s_data};  // 0 encodes 256
          idx_d   = '0;
          state_d = StHi;
        end
      end
      StHi: begin
        if (start) begin
          state_d = StLen;
        end else if (accept) begin
          if (s_data[7:4] != 4'h0) begin
            state_d = StErr;
          end else begin
            op_d    = instruction_t'(s_data[3:0]);
            state_d = StLo;
          end
        end
      end
      StLo: begin
        if (start) begin
          state_d = StLen;
        end else if (accept) begin
          buf_we  = 1'b1;
          idx_d   = idx_inc;
          // Pointer wraps at 256 words, so completion comes from the count.
          state_d = (idx_inc == cnt_q) ? StClr : StHi;
        end
      end
      StClr: begin
        buf_re  = 1'b1;
        idx_d   = '0;
        state_d = StStream;
      end
      StStream: begin
        // Prefetch the next word so the stream has no gaps.
        buf_re    = 1'b1;
        buf_raddr = idx_inc[AW-1:0];
        if (idx_inc == cnt_q) begin
          state_d = StBoot;
        end else begin
          idx_d = idx_inc;
        end
      end
      StBoot: state_d = StRun;
      StRun: begin
        if (start) begin
          state_d = StLen;
        end else if (stop) begin
          state_d = StIdle;
        end
      end
      StErr: if (start) state_d = StLen;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so outputs are registered with it.
  always_comb begin
    s_ready_d  = state_d inside {StLen, StHi, StLo};
    core_rst_d = !(state_d inside {StStream, StRun});
    pwrite_d   = state_d inside {StClr, StStream, StBoot};
    busy_d     = !(state_d inside {StIdle, StRun, StErr});
    running_d  = (state_d == StRun);
    err_d      = (state_d == StErr);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      op_q       <= OpNopo;
      s_ready_q  <= 1'b0;
      core_rst_q <= 1'b1;
      pwrite_q   <= 1'b0;
      busy_q     <= 1'b0;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      s_ready_q  <= s_ready_d;
      core_rst_q <= core_rst_d;
      pwrite_q   <= pwrite_d;
      busy_q     <= busy_d;
      running_q  <= running_d;
      err_q      <= err_d;
    end
  end

  mc14500b_prog_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_prog_buf (
    .clk_i  (clk),
    .we_i   (buf_we),
    .waddr_i(idx_q[AW-1:0]),
    .wdata_i({op_q, s_data}),
    .re_i   (buf_re),
    .raddr_i(buf_raddr),
    .rdata_o(buf_rdata)
  );

  assign s_ready            = s_ready_q;
  assign core_rst           = core_rst_q;
  assign core_program_write = pwrite_q;
  assign core_program_cmd   = (state_q == StStream) ? buf_rdata : '0;
  assign busy               = busy_q;
  assign running            = running_q;
  assign err                = err_q;

endmodule
